// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill sequencer.
// On a miss it issues the missing line plus sequential prefetch lines to the
// shared memory port. It tracks accepted requests by memory tag in a small
// outstanding-transaction table and turns returning data into I-cache fills.
// It yields the port to the D-cache, and a branch redirect cancels any
// prefetch that is still pending.
module icache_refill_ctrl #(
  parameter int XLEN     = 32,
  parameter int PF_DEPTH = 4,
  parameter int MSHR_NUM = 4,
  parameter int TAG_W    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        icache_miss,
  input  logic [XLEN-1:0]             icache_miss_addr,
  input  logic                        branch_taken,
  input  logic                        mem_port_busy,
  input  logic [TAG_W-1:0]            mem2proc_response,
  input  logic [TAG_W-1:0]            mem2proc_tag,
  input  logic [63:0]                 mem2proc_data,
  output logic [1:0]                  proc2mem_command,
  output logic [XLEN-1:0]             proc2mem_addr,
  output logic                        fill_valid,
  output logic [XLEN-1:0]             fill_addr,
  output logic [63:0]                 fill_data,
  output logic [$clog2(MSHR_NUM):0]   outstanding,
  output logic                        ctrl_busy
);

  localparam int LINE_W = XLEN - 3;
  localparam int REM_W  = $clog2(PF_DEPTH + 1);
  localparam int IDX_W  = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
  localparam int CNT_W  = $clog2(MSHR_NUM) + 1;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  // IDLE: nothing left to issue. ISSUE: lines pending and a table entry free.
  // FULL: lines pending but every table entry is occupied.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [LINE_W-1:0]        r_req_line;
  logic [REM_W-1:0]         r_remaining;
  logic [MSHR_NUM-1:0]      r_mshr_valid;
  logic [LINE_W-1:0]        r_mshr_line [MSHR_NUM];
  logic [TAG_W-1:0]         r_mshr_tag  [MSHR_NUM];
  logic                     r_fill_valid;
  logic [LINE_W-1:0]        r_fill_line;
  logic [63:0]              r_fill_data;
  logic [CNT_W-1:0]         r_outstanding;

  state_t                   w_next_state;
  logic [LINE_W-1:0]        w_miss_line;
  logic                     w_miss_hit;
  logic                     w_miss_new;
  logic                     w_dup;
  logic                     w_free_found;
  logic [IDX_W-1:0]         w_free_idx;
  logic                     w_ret_hit;
  logic [IDX_W-1:0]         w_ret_idx;
  logic                     w_issue;
  logic                     w_accept;
  logic [LINE_W-1:0]        w_req_line_next;
  logic [REM_W-1:0]         w_remaining_next;
  logic [MSHR_NUM-1:0]      w_valid_next;
  logic [CNT_W-1:0]         w_count_next;

  // Byte offset within a line never affects which line is fetched.
  logic w_unused_offset;
  assign w_unused_offset = &{1'b0, icache_miss_addr[2:0]};

  // Table lookups: miss/duplicate matching, lowest free entry, returning tag.
  // Also decides whether a request goes out and whether memory took it.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_miss_line  = icache_miss_addr[XLEN-1:3];
    // req_line only counts as in flight while prefetch is still pending;
    // once cancelled or drained it is just a stale pointer.
    w_miss_hit   = (r_remaining != '0) && (w_miss_line == r_req_line);
    w_dup        = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_ret_hit    = 1'b0;
    w_ret_idx    = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (r_mshr_valid[i] && (r_mshr_line[i] == w_miss_line)) begin
        w_miss_hit = 1'b1;
      end
      if (r_mshr_valid[i] && (r_mshr_line[i] == r_req_line)) begin
        w_dup = 1'b1;
      end
      if (!r_mshr_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_mshr_valid[i] && (mem2proc_tag != '0) &&
          (r_mshr_tag[i] == mem2proc_tag) && !w_ret_hit) begin
        w_ret_hit = 1'b1;
        w_ret_idx = IDX_W'(i);
      end
    end
    w_miss_new = icache_miss && !branch_taken && !w_miss_hit;
    w_issue    = (r_state == S_ISSUE) && w_free_found && !mem_port_busy &&
                 !branch_taken && !w_dup && !reset;
    w_accept   = w_issue && (mem2proc_response != '0);
  end

  // Next table occupancy: a return frees its entry, an accept claims the
  // lowest entry that was free at the start of the cycle.
  always_comb begin
    w_valid_next = r_mshr_valid;
    if (w_ret_hit) begin
      w_valid_next[w_ret_idx] = 1'b0;
    end
    if (w_accept) begin
      w_valid_next[w_free_idx] = 1'b1;
    end
    w_count_next = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      w_count_next = w_count_next + CNT_W'(w_valid_next[i]);
    end
  end

  // Next-state logic and memory request outputs.
  always_comb begin
    w_next_state     = r_state;
    w_req_line_next  = r_req_line;
    w_remaining_next = r_remaining;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;

    if (w_issue) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {r_req_line, 3'b000};
    end

    if (branch_taken) begin
      w_remaining_next = '0;
    end else if (w_miss_new) begin
      w_req_line_next  = w_miss_line;
      w_remaining_next = REM_W'(PF_DEPTH);
    end else if ((r_state == S_ISSUE) && (w_dup || w_accept)) begin
      // A line already in flight is skipped exactly like an accepted one.
      w_req_line_next  = r_req_line + LINE_W'(1);
      w_remaining_next = r_remaining - REM_W'(1);
    end

    if (w_remaining_next == '0) begin
      w_next_state = S_IDLE;
    end else if (~&w_valid_next) begin
      w_next_state = S_ISSUE;
    end else begin
      w_next_state = S_FULL;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request pointer, transaction table, fill pipeline and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_line    <= '0;
      r_remaining   <= '0;
      r_mshr_valid  <= '0;
      r_fill_valid  <= 1'b0;
      r_fill_line   <= '0;
      r_fill_data   <= '0;
      r_outstanding <= '0;
      // NOTE: the table is built from flops, so it is cleared outright; only
      // the valid bits matter, but zeroed line/tag fields keep stale tags
      // from a pre-reset transaction visibly dead.
      for (int i = 0; i < MSHR_NUM; i++) begin
        r_mshr_line[i] <= '0;
        r_mshr_tag[i]  <= '0;
      end
    end else begin
      r_req_line    <= w_req_line_next;
      r_remaining   <= w_remaining_next;
      r_mshr_valid  <= w_valid_next;
      r_outstanding <= w_count_next;
      if (w_accept) begin
        r_mshr_line[w_free_idx] <= r_req_line;
        r_mshr_tag[w_free_idx]  <= mem2proc_response;
      end
      r_fill_valid <= w_ret_hit;
      if (w_ret_hit) begin
        r_fill_line <= r_mshr_line[w_ret_idx];
        r_fill_data <= mem2proc_data;
      end
    end
  end

  assign fill_valid  = r_fill_valid;
  assign fill_addr   = {r_fill_line, 3'b000};
  assign fill_data   = r_fill_data;
  assign outstanding = r_outstanding;
  assign ctrl_busy   = (r_state != S_IDLE) || (r_outstanding != '0);

endmodule
